pipelined_adder_tree: RTL and testbench

//  Parametrised, fully pipelined reduction of TERMS operand meshes (LANES lanes each) into one LANES-wide result mesh.

---
 rtl/adder_tree_pkg.sv | 24 ++
 rtl/adder_tree_level.sv | 49 ++++
 rtl/pipelined_adder_tree.sv | 113 +++++++++++
 tb/tb_pipelined_adder_tree.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: mode encodings and sizing helpers shared by the adder tree blocks
package adder_tree_pkg;
  typedef enum logic [1:0] {
    MODE_TREE  = 2'd0,
    MODE_BIAS  = 2'd1,
    MODE_ACCUM = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int tree_levels(input int terms);
    return clog2(terms);
  endfunction
  function automatic int pad_terms(input int terms);
    return 1 << clog2(terms);
  endfunction
  function automatic int sum_width(input int in_bit, input int terms);
    return in_bit + clog2(terms);
  endfunction
endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered level of pairwise lane-wise adds plus the beat sideband
module adder_tree_level import adder_tree_pkg::*; #(
  parameter int N     = 2,
  parameter int LANES = 1,
  parameter int W     = 8,
  parameter int BW    = 9
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       in_valid,
  input  logic [1:0]                 in_mode,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [LANES*BW-1:0]        in_bias,
  input  logic [N*LANES*W-1:0]       in_data,
  output logic                       out_valid,
  output logic [1:0]                 out_mode,
  output logic                       out_first,
  output logic                       out_last,
  output logic [LANES*BW-1:0]        out_bias,
  output logic [(N/2)*LANES*W-1:0]   out_data
);
  logic [(N/2)*LANES*W-1:0] sum;
  // term 2p is paired with term 2p+1 in every lane; W has headroom so no overflow
  always_comb begin
    sum = '0;
    for (int p = 0; p < N/2; p++)
      for (int l = 0; l < LANES; l++)
        sum[(p*LANES+l)*W +: W] = in_data[(2*p*LANES+l)*W +: W] + in_data[((2*p+1)*LANES+l)*W +: W];
  end
  // level register; the whole beat, sideband included, only moves when ena is high
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= MODE_TREE;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_bias  <= '0;
      out_data  <= '0;
    end else if (ena) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_first <= in_first;
      out_last  <= in_last;
      out_bias  <= in_bias;
      out_data  <= sum;
    end
endmodule

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: pipelined TERMS-to-one mesh reduction with bias/accumulate modes; define ADDER_TREE_SAT_EN for saturating output
module pipelined_adder_tree import adder_tree_pkg::*; #(
  parameter int IN_BIT  = 20,
  parameter int OUT_BIT = 32,
  parameter int LANES   = 64,
  parameter int TERMS   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          in_valid,
  input  logic [1:0]                    in_mode,
  input  logic                          in_first,
  input  logic                          in_last,
  input  logic [TERMS*LANES*IN_BIT-1:0] data_in,
  input  logic [LANES*OUT_BIT-1:0]      inter_data,
  output logic                          out_valid,
  output logic [LANES*OUT_BIT-1:0]      data_out
);
  localparam int LEVELS = tree_levels(TERMS);
  localparam int PT     = pad_terms(TERMS);
  localparam int SW     = sum_width(IN_BIT, TERMS);
  localparam int BW     = OUT_BIT + 1;
  logic [PT*LANES*SW-1:0]   ext;
  logic [LANES*BW-1:0]      bias;
  logic [LANES*OUT_BIT-1:0] acc, res;
  logic [LANES-1:0]         unused_msb;
  logic                     tv, tf, tl;
  logic [1:0]               tm;
  logic [LANES*SW-1:0]      ts;
  logic [LANES*BW-1:0]      tb;
  for (genvar t = 0; t < PT; t++) begin : g_term
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (t < TERMS) begin : g_real
        assign ext[(t*LANES+l)*SW +: SW] = SW'(signed'(data_in[(t*LANES+l)*IN_BIT +: IN_BIT]));
      end else begin : g_pad
        assign ext[(t*LANES+l)*SW +: SW] = '0;
      end
    end
  end
  for (genvar l = 0; l < LANES; l++) begin : g_bias
    assign bias[l*BW +: BW] = BW'(signed'(inter_data[l*OUT_BIT +: OUT_BIT]));
  end
  for (genvar k = 0; k <= LEVELS; k++) begin : st
    logic [(PT>>k)*LANES*SW-1:0] d;
    logic                        v, f, la;
    logic [1:0]                  m;
    logic [LANES*BW-1:0]         b;
    if (k == 0) begin : g_in
      assign d  = ext;
      assign v  = in_valid;
      assign m  = in_mode == MODE_RSVD ? MODE_TREE : in_mode;
      assign f  = in_first;
      assign la = in_last;
      assign b  = bias;
    end else begin : g_lvl
      adder_tree_level #(.N(PT >> (k-1)), .LANES(LANES), .W(SW), .BW(BW)) u_lvl (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .in_valid  (st[k-1].v),
        .in_mode   (st[k-1].m),
        .in_first  (st[k-1].f),
        .in_last   (st[k-1].la),
        .in_bias   (st[k-1].b),
        .in_data   (st[k-1].d),
        .out_valid (v),
        .out_mode  (m),
        .out_first (f),
        .out_last  (la),
        .out_bias  (b),
        .out_data  (d)
      );
    end
  end
  assign tv = st[LEVELS].v;
  assign tm = st[LEVELS].m;
  assign tf = st[LEVELS].f;
  assign tl = st[LEVELS].la;
  assign ts = st[LEVELS].d;
  assign tb = st[LEVELS].b;
  // per-lane final arithmetic one bit wider than the output, then narrowed
  always_comb begin
    logic signed [BW-1:0] s, a, w;
    s = '0;
    a = '0;
    w = '0;
    res = '0;
    unused_msb = '0;
    for (int l = 0; l < LANES; l++) begin
      s = BW'(signed'(ts[l*SW +: SW]));
      a = tf ? '0 : BW'(signed'(acc[l*OUT_BIT +: OUT_BIT]));
      w = tm == MODE_BIAS ? s + signed'(tb[l*BW +: BW]) : tm == MODE_ACCUM ? a + s : s;
`ifdef ADDER_TREE_SAT_EN
      res[l*OUT_BIT +: OUT_BIT] = w[BW-1] != w[BW-2] ? {w[BW-1], {(OUT_BIT-1){~w[BW-1]}}} : w[OUT_BIT-1:0];
`else
      res[l*OUT_BIT +: OUT_BIT] = w[OUT_BIT-1:0];
      unused_msb[l] = w[BW-1];
`endif
    end
  end
  // result register and accumulator; bubbles and stalls leave both untouched
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      acc       <= '0;
    end else if (ena) begin
      out_valid <= tv && (tm != MODE_ACCUM || tl);
      if (tv && tm == MODE_ACCUM) acc <= res;
      if (tv && (tm != MODE_ACCUM || tl)) data_out <= res;
    end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// tb_pipelined_adder_tree: directed and randomized checks of the adder tree against a behavioural model
module tb_pipelined_adder_tree;
  localparam int IB = 20;
  localparam int OB = 32;
  localparam int LN = 4;
  localparam int TM = 5;
  localparam int LV = 3;
  localparam longint MAXV = (longint'(1) << (OB-1)) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  always #5 clk = ~clk;
  logic mv, mf, ml, mov;
  logic [1:0] mm;
  logic [TM*LN*IB-1:0] md;
  logic [LN*OB-1:0] mb, mout;
  logic bv, bov;
  logic [64*2*IB-1:0] bd;
  logic [2*OB-1:0] bout;
  logic sv, sov;
  logic [2*IB-1:0] sd;
  logic [19:0] sb, sout;
  pipelined_adder_tree #(.IN_BIT(IB), .OUT_BIT(OB), .LANES(LN), .TERMS(TM)) u_main (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(mv), .in_mode(mm), .in_first(mf), .in_last(ml),
    .data_in(md), .inter_data(mb), .out_valid(mov), .data_out(mout));
  pipelined_adder_tree #(.IN_BIT(IB), .OUT_BIT(OB), .LANES(2), .TERMS(64)) u_big (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(bv), .in_mode(2'd0), .in_first(1'b0), .in_last(1'b0),
    .data_in(bd), .inter_data('0), .out_valid(bov), .data_out(bout));
  pipelined_adder_tree #(.IN_BIT(IB), .OUT_BIT(20), .LANES(1), .TERMS(2)) u_sat (
    .clk(clk), .rst(rst), .ena(ena), .in_valid(sv), .in_mode(2'd1), .in_first(1'b0), .in_last(1'b0),
    .data_in(sd), .inter_data(sb), .out_valid(sov), .data_out(sout));
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  typedef struct { int due; logic [LN*OB-1:0] val; } exp_t;
  exp_t q[$];
  longint acc_m[LN];
  logic [LN*OB-1:0] last_out = '0;
  int adv = 0;
  function automatic longint narrow(input longint w);
`ifdef ADDER_TREE_SAT_EN
    return w > MAXV ? MAXV : w < -MAXV-1 ? -MAXV-1 : w;
`else
    logic signed [OB-1:0] t;
    t = w[OB-1:0];
    return t;
`endif
  endfunction
  task automatic accept();
    logic [LN*OB-1:0] r = '0;
    longint s, w;
    int m = (mm == 2'd3) ? 0 : int'(mm);
    for (int l = 0; l < LN; l++) begin
      s = 0;
      for (int t = 0; t < TM; t++) s += longint'(signed'(md[(t*LN+l)*IB +: IB]));
      w = m == 1 ? s + longint'(signed'(mb[l*OB +: OB])) : m == 2 ? (mf ? 0 : acc_m[l]) + s : s;
      w = narrow(w);
      if (m == 2) acc_m[l] = w;
      r[l*OB +: OB] = w[OB-1:0];
    end
    if (m != 2 || ml) q.push_back('{adv + LV, r});
  endtask
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      last_out = '0;
      for (int l = 0; l < LN; l++) acc_m[l] = 0;
    end else if (ena) begin
      adv++;
      if (mv) accept();
      #1;
      if (q.size() > 0 && q[0].due == adv) begin
        chk("out_valid", mov, 1'b1);
        chk("data_out", mout, q[0].val);
        last_out = q[0].val;
        void'(q.pop_front());
      end else begin
        chk("out_idle", mov, 1'b0);
        chk("data_hold", mout, last_out);
      end
    end
  end
  task automatic put(input logic v, input logic [1:0] m, input logic f, input logic l,
                     input int tv[TM], input int b);
    @(negedge clk);
    mv = v; mm = m; mf = f; ml = l;
    for (int t = 0; t < TM; t++)
      for (int k = 0; k < LN; k++) md[(t*LN+k)*IB +: IB] = IB'(tv[t]);
    for (int k = 0; k < LN; k++) mb[k*OB +: OB] = OB'(b);
  endtask
  task automatic wait_mov(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      mv = 1'b0;
      n++;
    end while (!mov && n < 30);
    chk(tag, mov, 1'b1);
  endtask
  initial begin
    int n;
    mv = 0; mm = 0; mf = 0; ml = 0; md = '0; mb = '0;
    bv = 0; bd = '0; sv = 0; sd = '0; sb = '0;
    repeat (3) @(negedge clk);
    chk("rst_valids", {mov, bov, sov}, 3'b000);
    chk("rst_main", mout, '0);
    chk("rst_big", bout, '0);
    chk("rst_sat", sout, '0);
    rst = 1'b0;
    put(1, 2'd1, 0, 0, '{-3, 7, 2, -1, 4}, 100);
    wait_mov("pad_timeout", n);
    chk("pad_latency", n, LV + 1);
    chk("pad_value", mout, {LN{32'd109}});
    for (int t = 0; t < 64; t++) bd[(t*2)*IB +: IB] = IB'(1);
    @(negedge clk);
    bv = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; bv = 1'b0; n++; end while (!bov && n < 30);
    chk("big_latency", n, 7);
    chk("big_value", bout, {32'd0, 32'd64});
    sd = {20'd0, 20'h7FFFF};
    sb = 20'd1;
    @(negedge clk);
    sv = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; sv = 1'b0; n++; end while (!sov && n < 30);
    chk("sat_latency", n, 2);
`ifdef ADDER_TREE_SAT_EN
    chk("sat_pos", sout, 20'h7FFFF);
`else
    chk("wrap_pos", sout, 20'h80000);
`endif
    sd = {20'd0, 20'h80000};
    sb = 20'hFFFFF;
    @(negedge clk);
    sv = 1'b1;
    n = 0;
    do begin @(posedge clk); #2; sv = 1'b0; n++; end while (!sov && n < 30);
`ifdef ADDER_TREE_SAT_EN
    chk("sat_neg", sout, 20'h80000);
`else
    chk("wrap_neg", sout, 20'h7FFFF);
`endif
    put(1, 2'd2, 1, 0, '{10, 0, 0, 0, 0}, 0);
    put(1, 2'd2, 0, 0, '{20, 0, 0, 0, 0}, 0);
    put(1, 2'd2, 0, 1, '{-5, 0, 0, 0, 0}, 0);
    put(1, 2'd2, 1, 1, '{3, 4, 0, 0, 0}, 0);
    wait_mov("acc_timeout", n);
    chk("acc_latency", n, LV);
    chk("acc_value", mout, {LN{32'd25}});
    @(posedge clk);
    #2;
    chk("single_valid", mov, 1'b1);
    chk("single_value", mout, {LN{32'd7}});
    put(1, 2'd0, 0, 0, '{1, 0, 0, 0, 0}, 0);
    put(1, 2'd0, 0, 0, '{2, 0, 0, 0, 0}, 0);
    put(1, 2'd0, 0, 0, '{99, 0, 0, 0, 0}, 0);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    put(1, 2'd0, 0, 0, '{3, 0, 0, 0, 0}, 0);
    ena = 1'b1;
    put(1, 2'd0, 0, 0, '{4, 0, 0, 0, 0}, 0);
    wait_mov("stall_timeout", n);
    chk("stall_latency", n, 1);
    chk("stall_first", mout, {LN{32'd1}});
    @(posedge clk);
    #2;
    chk("stall_second", mout, {LN{32'd2}});
    repeat (400) begin
      @(negedge clk);
      ena = $urandom_range(0, 9) != 0;
      mv = $urandom_range(0, 3) != 0;
      mm = 2'($urandom);
      mf = $urandom_range(0, 3) == 0;
      ml = $urandom_range(0, 2) == 0;
      for (int t = 0; t < TM; t++)
        for (int k = 0; k < LN; k++) md[(t*LN+k)*IB +: IB] = IB'($urandom);
      for (int k = 0; k < LN; k++)
        case ($urandom_range(0, 2))
          0: mb[k*OB +: OB] = 32'h7FFFFFFF - 32'($urandom_range(0, 3000000));
          1: mb[k*OB +: OB] = 32'h80000000 + 32'($urandom_range(0, 3000000));
          default: mb[k*OB +: OB] = $urandom;
        endcase
    end
    @(negedge clk);
    ena = 1'b1;
    mv = 1'b0;
    repeat (LV + 3) @(negedge clk);
    put(1, 2'd0, 0, 0, '{6, 0, 0, 0, 0}, 0);
    put(1, 2'd2, 1, 0, '{50, 0, 0, 0, 0}, 0);
    put(1, 2'd2, 0, 0, '{60, 0, 0, 0, 0}, 0);
    @(negedge clk);
    mv = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", mov, 1'b0);
    chk("rst_async_data", mout, '0);
    @(negedge clk);
    rst = 1'b0;
    put(1, 2'd2, 0, 1, '{9, 0, 0, 0, 0}, 0);
    wait_mov("post_rst_timeout", n);
    chk("post_rst_latency", n, LV + 1);
    chk("post_rst_value", mout, {LN{32'd9}});
    repeat (LV + 3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
